pipe_logic_unit: RTL

// - Parametrised, pipelined successor of the execute-stage logic/shift unit: AND/OR/XOR, shifts,
//   CSR set/clear, plus ANDN/ORN/XNOR, ROL/ROR and RV64 word (W) variants.
// - Sits in the EX stage beside the adder; valid/ready on both sides, tag carried for writeback.
// - Fully pipelined, one op per cycle, fixed latency PIPE_STAGES, flushable on redirect.

---
 rtl/pipe_logic_unit_pkg.sv | 40 ++++
 rtl/pipe_logic_unit_if.sv | 32 +++
 rtl/pipe_logic_unit_shifter.sv | 67 ++++++
 rtl/pipe_logic_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pipe_logic_unit_pkg.sv
// Shared opcode encoding and decode helpers for the EX-stage logic/shift unit.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package pipe_logic_pkg;

    typedef enum logic [3:0] {
        OP_AND  = 4'd0,
        OP_OR   = 4'd1,
        OP_XOR  = 4'd2,
        OP_SLL  = 4'd3,
        OP_SRL  = 4'd4,
        OP_SRA  = 4'd5,
        OP_ROL  = 4'd6,
        OP_ROR  = 4'd7,
        OP_CSRS = 4'd8,
        OP_CSRC = 4'd9,
        OP_ANDN = 4'd10,
        OP_ORN  = 4'd11,
        OP_XNOR = 4'd12
    } op_e;

    // Codes above OP_LAST (13-15) are undefined and decode as illegal.
    localparam logic [3:0] OP_LAST = 4'd12;

    localparam int XLEN_RV32 = 32;
    localparam int XLEN_RV64 = 64;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op >= OP_SLL) && (op <= OP_ROR);
    endfunction

    function automatic logic op_is_defined(input logic [3:0] op);
        return op <= OP_LAST;
    endfunction

    function automatic logic xlen_is_legal(input int xlen);
        return (xlen == XLEN_RV32) || (xlen == XLEN_RV64);
    endfunction

endpackage

// File: rtl/pipe_logic_unit_if.sv
// Handshake/bus bundle between the issue logic and the logic/shift unit.
// Latency: n/a (wires only).
// Backpressure: in_ready and out_ready carry valid/ready flow control on each side.
interface pipe_logic_unit_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       op;
    logic             word;
    logic [XLEN-1:0]  op1;
    logic [XLEN-1:0]  op2;
    logic [TAG_W-1:0] tag;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  result;
    logic [TAG_W-1:0] tag_out;
    logic             illegal;

    // master: the issuing/consuming side; slave: the unit itself
    modport master (
        output in_valid, op, word, op1, op2, tag, flush, out_ready,
        input  in_ready, out_valid, result, tag_out, illegal
    );

    modport slave (
        input  in_valid, op, word, op1, op2, tag, flush, out_ready,
        output in_ready, out_valid, result, tag_out, illegal
    );
endinterface

// File: rtl/pipe_logic_unit_shifter.sv
// Log2 barrel shifter: SLL/SRL/SRA/ROL/ROR, full width or 32-bit word mode.
// Latency: combinational.
// Backpressure: none (pure function of its inputs).
// Ports: a (value), shamt (amount), left/arith/rotate/word (mode), y (result).
module logic_shifter_core #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]         a,
    input  logic [$clog2(XLEN)-1:0] shamt,
    input  logic                    left,
    input  logic                    arith,
    input  logic                    rotate,
    input  logic                    word,
    output logic [XLEN-1:0]         y
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] ONES = '1;

    logic [SHW-1:0]  sh;
    logic            fill;
    logic [31:0]     v32;
    logic [31:0]     r32;
    logic [XLEN-1:0] x;
    int              amt;

    // Everything is done as a right shift/rotate; left ops bit-reverse
    // before and after. Word mode places the 32-bit value in the low half
    // and fills the upper half so the right shift pulls in the right bits:
    // a copy of the value for rotates, the fill bit otherwise.
    always_comb begin
        sh   = shamt;
        amt  = 0;
        v32  = '0;
        r32  = '0;
        x    = '0;
        y    = '0;
        if (word) begin
            for (int i = 5; i < SHW; i++) sh[i] = 1'b0;
        end
        fill = arith && (word ? a[31] : a[XLEN-1]);

        for (int i = 0; i < 32; i++) v32[i] = left ? a[31-i] : a[i];
        if (word) begin
            x[31:0] = v32;
            for (int i = 32; i < XLEN; i++) x[i] = rotate ? v32[i-32] : fill;
        end else begin
            for (int i = 0; i < XLEN; i++) x[i] = left ? a[XLEN-1-i] : a[i];
        end

        for (int s = 0; s < SHW; s++) begin
            amt = 1 << s;
            if (sh[s]) begin
                if (rotate)    x = (x >> amt) | (x << (XLEN - amt));
                else if (fill) x = (x >> amt) | ~(ONES >> amt);
                else           x = x >> amt;
            end
        end

        if (word) begin
            for (int i = 0; i < 32; i++) r32[i] = left ? x[31-i] : x[i];
            y[31:0] = r32;
            for (int i = 32; i < XLEN; i++) y[i] = r32[31];
        end else begin
            for (int i = 0; i < XLEN; i++) y[i] = left ? x[XLEN-1-i] : x[i];
        end
    end
endmodule

// File: rtl/pipe_logic_unit.sv
// EX-stage logic/shift unit: AND/OR/XOR/ANDN/ORN/XNOR, CSRS/CSRC, shifts/rotates (+W forms).
// Latency: PIPE_STAGES cycles accept-to-result (result always registered), 1 op/cycle.
// Backpressure: a stalled result holds stable; stages load only when empty or draining.
// Ports: clk_i, rst_i (async active-high), bus (slave modport: in handshake + op/word/op1/op2/tag,
//        flush, out handshake + result/tag_out/illegal).
module pipe_logic_unit
    import pipe_logic_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int PIPE_STAGES = 1,
    parameter int TAG_W       = 5
) (
    input logic              clk_i,
    input logic              rst_i,
    pipe_logic_unit_if.slave bus
);
    localparam int SHW      = $clog2(XLEN);
    localparam bit HAS_WORD = (XLEN == XLEN_RV64);

    if (!xlen_is_legal(XLEN) || (PIPE_STAGES != 1 && PIPE_STAGES != 2)) begin : g_param_check
        $error("pipe_logic_unit: unsupported XLEN or PIPE_STAGES");
    end

    // Operands as seen by the result stage (either the bus or the decode register).
    logic             c_vld;
    logic [3:0]       c_op;
    logic             c_word;
    logic [XLEN-1:0]  c_op1;
    logic [XLEN-1:0]  c_op2;
    logic [TAG_W-1:0] c_tag;
    logic             c_ill;

    logic             res_vld;
    logic [XLEN-1:0]  res_dat;
    logic [TAG_W-1:0] res_tag;
    logic             res_ill;

    logic             res_load_ok;
    logic             in_fire;
    logic             in_ill;

    assign res_load_ok = !res_vld || bus.out_ready;
    assign in_fire     = bus.in_valid && bus.in_ready;
    assign in_ill      = !op_is_defined(bus.op) ||
                         (bus.word && (!is_shift_op(bus.op) || !HAS_WORD));

    if (PIPE_STAGES == 1) begin : g_one_stage
        assign bus.in_ready = !rst_i && !bus.flush && res_load_ok;
        assign c_vld  = bus.in_valid;
        assign c_op   = bus.op;
        assign c_word = bus.word;
        assign c_op1  = bus.op1;
        assign c_op2  = bus.op2;
        assign c_tag  = bus.tag;
        assign c_ill  = in_ill;
    end else begin : g_two_stage
        logic             s1_vld;
        logic [3:0]       s1_op;
        logic             s1_word;
        logic [XLEN-1:0]  s1_op1;
        logic [XLEN-1:0]  s1_op2;
        logic [TAG_W-1:0] s1_tag;
        logic             s1_ill;

        // Stage 1 may refill in the same cycle it hands its op to the result stage.
        assign bus.in_ready = !rst_i && !bus.flush && (!s1_vld || res_load_ok);

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                s1_vld  <= 1'b0;
                s1_op   <= '0;
                s1_word <= 1'b0;
                s1_op1  <= '0;
                s1_op2  <= '0;
                s1_tag  <= '0;
                s1_ill  <= 1'b0;
            end else if (bus.flush) begin
                s1_vld <= 1'b0;
            end else if (in_fire) begin
                s1_vld  <= 1'b1;
                s1_op   <= bus.op;
                s1_word <= bus.word;
                s1_op1  <= bus.op1;
                s1_op2  <= bus.op2;
                s1_tag  <= bus.tag;
                s1_ill  <= in_ill;
            end else if (res_load_ok) begin
                s1_vld <= 1'b0;
            end
        end

        assign c_vld  = s1_vld;
        assign c_op   = s1_op;
        assign c_word = s1_word;
        assign c_op1  = s1_op1;
        assign c_op2  = s1_op2;
        assign c_tag  = s1_tag;
        assign c_ill  = s1_ill;
    end

    logic            sh_left;
    logic            sh_arith;
    logic            sh_rot;
    logic            sh_word;
    logic [XLEN-1:0] sh_y;
    logic [XLEN-1:0] c_res;

    always_comb begin
        sh_left  = (c_op == OP_SLL) || (c_op == OP_ROL);
        sh_arith = (c_op == OP_SRA);
        sh_rot   = (c_op == OP_ROL) || (c_op == OP_ROR);
        sh_word  = c_word && HAS_WORD;
    end

    logic_shifter_core #(.XLEN(XLEN)) u_shifter (
        .a      (c_op1),
        .shamt  (c_op2[SHW-1:0]),
        .left   (sh_left),
        .arith  (sh_arith),
        .rotate (sh_rot),
        .word   (sh_word),
        .y      (sh_y)
    );

    // Illegal ops still complete, but with a zero result.
    always_comb begin
        c_res = '0;
        if (!c_ill) begin
            case (c_op)
                OP_AND:  c_res = c_op1 & c_op2;
                OP_OR:   c_res = c_op1 | c_op2;
                OP_XOR:  c_res = c_op1 ^ c_op2;
                OP_ANDN: c_res = c_op1 & ~c_op2;
                OP_ORN:  c_res = c_op1 | ~c_op2;
                OP_XNOR: c_res = ~(c_op1 ^ c_op2);
                OP_CSRS: c_res = c_op1 | c_op2;
                OP_CSRC: c_res = c_op1 & ~c_op2;
                OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR: c_res = sh_y;
                default: c_res = '0;
            endcase
        end
    end

    // Flush wins over both drain and load; data regs hold while stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            res_vld <= 1'b0;
            res_dat <= '0;
            res_tag <= '0;
            res_ill <= 1'b0;
        end else if (bus.flush) begin
            res_vld <= 1'b0;
        end else if (c_vld && res_load_ok) begin
            res_vld <= 1'b1;
            res_dat <= c_res;
            res_tag <= c_tag;
            res_ill <= c_ill;
        end else if (bus.out_ready) begin
            res_vld <= 1'b0;
        end
    end

    assign bus.out_valid = res_vld;
    assign bus.result    = res_dat;
    assign bus.tag_out   = res_tag;
    assign bus.illegal   = res_ill;
endmodule
